alu_sel_ctrl: RTL and testbench
===============================

// Module: alu_sel_ctrl
// PURPOSE
//  Front-panel operation selector directly upstream of the ALU/display top: turns two raw push
//  buttons into the 3-bit ALU select code. Synchronises and debounces each button, detects presses,
//  and steps select up/down with wrap-around. Pulses sel_changed whenever select takes a new value.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive cycles the synchronised input must differ from stable state to flip it (>=2)
//  REPEAT_DELAY     50000000 cycles a press is held before the first auto-repeat step (AUTO_REPEAT_EN only)
//  REPEAT_RATE      10000000 cycles between subsequent auto-repeat steps (AUTO_REPEAT_EN only)
//  SEL_INIT         3'd0     select value after reset
// PORTS
//  clkin        in   1  system clock; all logic on rising edge
//  rst          in   1  synchronous, active-high reset
//  btn_inc      in   1  raw asynchronous button, 1 = pressed; step select +1
//  btn_dec      in   1  raw asynchronous button, 1 = pressed; step select -1
//  select       out  3  current ALU operation code (registered)
//  sel_changed  out  1  one-cycle pulse, high in the same cycle select first shows its new value
//  btn_level    out  2  debounced stable levels {dec,inc}, for LED feedback
// BEHAVIOUR
//  - Reset (rst=1 at an edge): select=SEL_INIT, sel_changed=0, btn_level=0. Synchroniser FFs,
//    debounce counters, press-edge registers and repeat FSMs clear. Reset mid-press discards the
//    press; a button still held after reset must debounce again before it produces a step.
//  - Sync: 2-FF synchroniser per button (s1<=raw, s2<=s1).
//  - Debounce, per button: cnt increments on each edge where s2!=stable; cnt clears on any edge
//    where s2==stable. When s2!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s2, cnt<=0.
//    Glitches shorter than DEBOUNCE_CYCLES never change stable.
//  - Press event: stable 0->1 (compared with registered stable_d). Release produces no step.
//  - Latency: raw held high from before edge 1 -> stable high after edge DEBOUNCE_CYCLES+2 ->
//    select and sel_changed update at edge DEBOUNCE_CYCLES+3.
//  - Step: inc event: select<=select+1 mod 8 (7->0). Dec event: select<=select-1 mod 8 (0->7).
//    Inc and dec events in the same cycle cancel: select holds, sel_changed=0.
//    sel_changed=1 only on the cycle after a step, else 0.
//  - Repeat FSM per button (states IDLE, HELD, REPEAT; single 32-bit timer):
//    IDLE --press--> HELD (timer<=0); HELD/REPEAT --stable==0--> IDLE.
//    Without the macro, HELD is terminal until release (one step per press).
// CONFIGURATION
//  AUTO_REPEAT_EN defined: in HELD, timer counts; at timer==REPEAT_DELAY-1 emit a step event,
//    go to REPEAT, timer<=0; in REPEAT, emit a step each time timer==REPEAT_RATE-1, then timer<=0.
//    Repeat events follow the same cancel and wrap rules as press events.
//  AUTO_REPEAT_EN undefined: no timers synthesised; holding a button gives exactly one step.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5, SEL_INIT=0)
//  1. rst 2 cycles, btn_inc raised before edge 1 and held -> select=0 through edge 6; select=1 and
//     sel_changed=1 at edge 7; sel_changed=0 at edge 8.
//  2. btn_inc 3-cycle glitch -> btn_level[0] never rises, select stays 0, no sel_changed.
//  3. From select=7, one clean inc press -> select=0. From select=0, one dec press -> select=7.
//  4. Both buttons raised on the same edge and held -> stable levels rise together, select
//     unchanged, sel_changed never asserted.
//  5. AUTO_REPEAT_EN, btn_inc held 40 cycles from select=0 -> steps at edges 7, 17, 22, 27, 32, 37
//     (select 1..6). Without the macro -> single step to 1.
//  6. rst asserted while btn_dec has cnt=2 -> select=SEL_INIT; btn_dec still held -> one step to 7
//     exactly DEBOUNCE_CYCLES+3 edges after rst deasserts.

Source files
------------

// File: rtl/alu_sel_ctrl.sv
// alu_sel_ctrl: two debounced push buttons step a 3-bit ALU select code up/down with wrap.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat stepping on each button.
`default_nettype none

module alu_sel_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
`ifdef AUTO_REPEAT_EN
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_RATE     = 10000000,
`endif
   parameter logic [2:0]  SEL_INIT        = 3'd0
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic       btn_inc,
   input  logic       btn_dec,
   output logic [2:0] select,
   output logic       sel_changed,
   output logic [1:0] btn_level
);

   localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HELD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

`ifdef AUTO_REPEAT_EN
   localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] RATE_LAST  = 32'(REPEAT_RATE - 1);
`endif

   logic [1:0] raw_w;
   logic [1:0] step_w;
   logic [1:0] level_w;

   assign raw_w = {btn_dec, btn_inc};

   // Bit 0 is the increment button, bit 1 the decrement button.
   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          s1_q;
      logic          s2_q;
      logic          stable_q;
      logic          stable_dly_q;
      logic [CW-1:0] cnt_q;
      logic [1:0]    state_q;
      logic [1:0]    state_d;
      logic          press_w;
      logic          rep_fire_w;

      always_ff @(posedge clkin) begin
         if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
         end else begin
            s1_q         <= raw_w[gi];
            s2_q         <= s1_q;
            stable_dly_q <= stable_q;
            if (s2_q != stable_q) begin
               if (cnt_q == CNT_LAST) begin
                  stable_q <= s2_q;
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end else begin
               cnt_q <= '0;
            end
         end
      end

      assign press_w = stable_q & ~stable_dly_q;

      always_ff @(posedge clkin) begin
         if (rst) state_q <= ST_IDLE;
         else     state_q <= state_d;
      end

`ifdef AUTO_REPEAT_EN
      logic [31:0] timer_q;

      always_ff @(posedge clkin) begin
         if (rst || state_q == ST_IDLE || rep_fire_w) timer_q <= '0;
         else                                        timer_q <= timer_q + 32'd1;
      end
`endif

      always_comb begin
         state_d = state_q;
         case (state_q)
            ST_IDLE:   if (press_w) state_d = ST_HELD;
            ST_HELD: begin
               if (!stable_q) state_d = ST_IDLE;
`ifdef AUTO_REPEAT_EN
               else if (timer_q == DELAY_LAST) state_d = ST_REPEAT;
`endif
            end
            ST_REPEAT: if (!stable_q) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end

      always_comb begin
         rep_fire_w = 1'b0;
`ifdef AUTO_REPEAT_EN
         if (stable_q && state_q == ST_HELD && timer_q == DELAY_LAST)  rep_fire_w = 1'b1;
         if (stable_q && state_q == ST_REPEAT && timer_q == RATE_LAST) rep_fire_w = 1'b1;
`endif
      end

      assign step_w[gi]  = press_w | rep_fire_w;
      assign level_w[gi] = stable_q;
   end

   logic [2:0] select_q;
   logic [2:0] select_d;
   logic       changed_q;

   // Simultaneous inc and dec steps cancel out.
   always_comb begin
      select_d = select_q;
      if (step_w[0] && !step_w[1])      select_d = select_q + 3'd1;
      else if (step_w[1] && !step_w[0]) select_d = select_q - 3'd1;
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         select_q  <= SEL_INIT;
         changed_q <= 1'b0;
      end else begin
         select_q  <= select_d;
         changed_q <= step_w[0] ^ step_w[1];
      end
   end

   assign select      = select_q;
   assign sel_changed = changed_q;
   assign btn_level   = level_w;

endmodule

`default_nettype wire

// File: tb/tb_alu_sel_ctrl.sv
// Testbench for alu_sel_ctrl: directed scenarios plus random button activity against a reference model.
`default_nettype none

module tb_alu_sel_ctrl;

   localparam int DEB   = 4;
   localparam int DELAY = 10;
   localparam int RATE  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_inc = 1'b0;
   logic       btn_dec = 1'b0;
   logic [2:0] select;
   logic       sel_changed;
   logic [1:0] btn_level;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_sel_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
`ifdef AUTO_REPEAT_EN
      .REPEAT_DELAY(DELAY),
      .REPEAT_RATE(RATE),
`endif
      .SEL_INIT(3'd0)
   ) dut (
      .clkin(clk),
      .rst(rst),
      .btn_inc(btn_inc),
      .btn_dec(btn_dec),
      .select(select),
      .sel_changed(sel_changed),
      .btn_level(btn_level)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Steps are counted as pending events resolved at the following edge; auto-repeat is
   // derived from the number of edges the press has been held.
   int m_sel;
   bit m_chg;
   bit m_pipe1[2], m_pipe2[2], m_stb[2], m_press[2], m_pend[2], m_held[2];
   int m_run[2], m_age[2];
   bit m_valid = 0;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_sel = 0; m_chg = 0; m_valid = 1;
         for (int i = 0; i < 2; i++) begin
            m_pipe1[i] = 0; m_pipe2[i] = 0; m_stb[i] = 0; m_press[i] = 0;
            m_pend[i] = 0; m_held[i] = 0; m_run[i] = 0; m_age[i] = 0;
         end
      end else begin
         if (m_pend[0] != m_pend[1]) begin
            m_sel = m_pend[0] ? (m_sel + 1) % 8 : (m_sel + 7) % 8;
            m_chg = 1;
         end else begin
            m_chg = 0;
         end
         for (int i = 0; i < 2; i++) begin
            bit old_stb;
            bit raw;
            raw = (i == 0) ? btn_inc : btn_dec;
            if (m_press[i]) begin
               m_held[i] = 1; m_age[i] = 0;
            end else if (m_held[i]) begin
               m_age[i]++;
            end
            old_stb = m_stb[i];
            if (m_pipe2[i] != m_stb[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_stb[i] = m_pipe2[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
            m_pipe2[i] = m_pipe1[i];
            m_pipe1[i] = raw;
            if (!m_stb[i]) m_held[i] = 0;
            m_press[i] = m_stb[i] && !old_stb;
            m_pend[i]  = m_press[i];
`ifdef AUTO_REPEAT_EN
            if (m_held[i] && m_stb[i] && m_age[i] >= DELAY - 1 &&
                ((m_age[i] - (DELAY - 1)) % RATE) == 0)
               m_pend[i] = 1;
`endif
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("model_select", 32'(select), 32'(m_sel));
         chk("model_sel_changed", 32'(sel_changed), 32'(m_chg));
         chk("model_btn_level", 32'(btn_level), 32'({m_stb[1], m_stb[0]}));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit is_dec);
      if (is_dec) btn_dec = 1'b1; else btn_inc = 1'b1;
      wait_n(9);
      btn_inc = 1'b0; btn_dec = 1'b0;
      wait_n(10);
   endtask

   int exp_rep[$];
   int got_rep[$];
   int cnt_a, cnt_b;
   int cd[2];

   initial begin
      // 1: reset then held inc press latency
      rst = 1'b1; btn_inc = 1'b1; btn_dec = 1'b0;
      wait_n(2);
      chk("reset_select", 32'(select), 0);
      chk("reset_sel_changed", 32'(sel_changed), 0);
      chk("reset_btn_level", 32'(btn_level), 0);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k <= 6) chk("lat_hold_select", 32'(select), 0);
         if (k == 7) begin
            chk("lat_step_select", 32'(select), 1);
            chk("lat_step_changed", 32'(sel_changed), 1);
         end
         if (k == 8) chk("lat_pulse_end", 32'(sel_changed), 0);
      end
      btn_inc = 1'b0;
      wait_n(12);

      // 2: short glitch is filtered
      btn_inc = 1'b1; wait_n(3); btn_inc = 1'b0;
      cnt_a = 0; cnt_b = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (btn_level[0]) cnt_a++;
         if (sel_changed) cnt_b++;
      end
      chk("glitch_level", 32'(cnt_a), 0);
      chk("glitch_changed", 32'(cnt_b), 0);
      chk("glitch_select", 32'(select), 1);

      // 3: wrap in both directions
      for (int k = 0; k < 6; k++) press(1'b0);
      chk("up_to_7", 32'(select), 7);
      press(1'b0);
      chk("wrap_7_to_0", 32'(select), 0);
      press(1'b1);
      chk("wrap_0_to_7", 32'(select), 7);

      // 4: both buttons together cancel
      btn_inc = 1'b1; btn_dec = 1'b1;
      cnt_b = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (sel_changed) cnt_b++;
      end
      chk("both_changed", 32'(cnt_b), 0);
      chk("both_select", 32'(select), 7);
      chk("both_level", 32'(btn_level), 3);
      btn_inc = 1'b0; btn_dec = 1'b0;
      wait_n(12);

      // 5: long hold from reset
      exp_rep = {7};
`ifdef AUTO_REPEAT_EN
      exp_rep = {7, 17, 22, 27, 32, 37};
`endif
      rst = 1'b1; btn_inc = 1'b1;
      wait_n(2);
      rst = 1'b0;
      got_rep = {};
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (sel_changed) got_rep.push_back(k);
      end
      chk("hold_step_count", 32'(got_rep.size()), 32'(exp_rep.size()));
      for (int i = 0; i < exp_rep.size() && i < got_rep.size(); i++)
         chk("hold_step_edge", 32'(got_rep[i]), 32'(exp_rep[i]));
      chk("hold_final_select", 32'(select), 32'(exp_rep.size()));
      btn_inc = 1'b0;
      wait_n(12);

      // 6: reset during debounce of a held dec button
      btn_dec = 1'b1;
      wait_n(4);
      rst = 1'b1;
      wait_n(2);
      chk("midpress_reset_select", 32'(select), 0);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 6) chk("midpress_hold", 32'(select), 0);
         if (k == 7) begin
            chk("midpress_step", 32'(select), 7);
            chk("midpress_changed", 32'(sel_changed), 1);
         end
      end
      btn_dec = 1'b0;
      wait_n(12);

      // random activity with occasional resets
      cd[0] = 0; cd[1] = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (cd[i] == 0) begin
               if (i == 0) btn_inc = 1'($urandom_range(0, 1));
               else        btn_dec = 1'($urandom_range(0, 1));
               cd[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                   : int'($urandom_range(1, 8));
            end else begin
               cd[i]--;
            end
         end
         rst = ($urandom_range(0, 599) == 0);
      end
      rst = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
      wait_n(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
